// File: rtl/adder_nibble_seq.sv
// Sequential adder: one 4-bit slice reused per cycle, LS nibble first, carry held in a register.
// Optional subtract mode is compiled in when ADDER_NIBBLE_SEQ_SUB_EN is defined.
module adder_nibble_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = $clog2(NIBBLES);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      res_q, res_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;

    logic              sub_eff;
    logic [IdxW+1:0]   base;
    logic [3:0]        nib_a, nib_b;
    logic [4:0]        slice_sum;

`ifdef ADDER_NIBBLE_SEQ_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // The single 4-bit slice; its carry only ever reaches the next nibble through carry_q.
    assign base      = {idx_q, 2'b00};
    assign nib_a     = a_q[base +: 4];
    assign nib_b     = b_q[base +: 4];
    assign slice_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = op_a;
                    // Subtraction: A + ~B + 1, so invert B once at capture.
                    b_d     = sub_eff ? ~op_b : op_b;
                    carry_d = sub_eff ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d[base +: 4] = slice_sum[3:0];
                carry_d          = slice_sum[4];
                if (idx_q == IdxLast) begin
                    cout_d  = slice_sum[4];
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy   = (state_q == StRun) || (state_q == StDone);
    assign done   = (state_q == StDone);
    assign result = res_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_adder_nibble_seq.sv
// Randomized self-checking bench for adder_nibble_seq against a plain-arithmetic sum model.
// Subtract tests are included when ADDER_NIBBLE_SEQ_SUB_EN is defined.
module tb_adder_nibble_seq;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_nibble_seq #(.NIBBLES(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin     (cin),
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else   r = {1'b0, a} + {1'b0, b} + (W+1)'(c);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[W-1:0];
    endfunction

    // Called at a negedge with start low; returns at the negedge after the accepting edge.
    task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                             input logic s);
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
        op_a = rnd_op();
        op_b = rnd_op();
        cin  = $urandom_range(0, 1);
        sub  = ($urandom_range(0, 1) == 1);
    endtask

    task automatic wait_done(input logic [W:0] exp, input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 40);
        check_eq({tag, "_latency"}, 64'(k), 64'(N));
        check_eq({tag, "_result"}, 64'(result), 64'(exp[W-1:0]));
        check_eq({tag, "_cout"}, 64'(cout), 64'(exp[W]));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, "_idle"}, 64'(busy), 64'd0);
        check_eq({tag, "_hold"}, 64'({cout, result}), 64'(exp));
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic c, s;
        logic [W:0] exp_a;

        #1;
        check_eq("reset_result", 64'(result), 64'd0);
        check_eq("reset_cout", 64'(cout), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        start_add(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(17'h05555, "basic");

        start_add(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_done(17'h10000, "ripple");

        // start held high: first add runs undisturbed, second starts in the IDLE cycle after done
        exp_a = ref_sum(16'hA5A5, 16'h5A5B, 1'b0, 1'b0);
        op_a  = 16'hA5A5;
        op_b  = 16'h5A5B;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_eq("held_busy", 64'(busy), 64'd1);
        op_a = 16'h0F0F;
        op_b = 16'h1111;
        cin  = 1'b1;
        wait_done(exp_a, "held_first");
        @(negedge clk);
        check_eq("held_second_accept", 64'(busy), 64'd1);
        start = 1'b0;
        wait_done(ref_sum(16'h0F0F, 16'h1111, 1'b1, 1'b0), "held_second");

        // reset during nibble 2
        start_add(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        #1;
        check_eq("abort_result", 64'(result), 64'd0);
        check_eq("abort_cout", 64'(cout), 64'd0);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_done", 64'({busy, done}), 64'd0);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        start_add(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done(17'h00002, "post_reset");

`ifdef ADDER_NIBBLE_SEQ_SUB_EN
        start_add(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(17'h0FFFE, "sub_borrow");
        start_add(16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_done(17'h10002, "sub_noborrow");
`endif

        for (int i = 0; i < 300; i++) begin
            a = rnd_op();
            b = rnd_op();
            c = $urandom_range(0, 1);
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
            s = ($urandom_range(0, 1) == 1);
`else
            s = 1'b0;
`endif
            if (i % 10 == 0) a = '1;
            start_add(a, b, c, s);
            wait_done(ref_sum(a, b, c, s), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
